csw_recorder: RTL

CSW_RECORDER -- requirements
Module: csw_recorder

---
 rtl/csw_recorder_pkg.sv | 37 +++
 rtl/csw_run_fifo.sv | 58 +++++
 rtl/csw_recorder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/csw_recorder_pkg.sv
// Shared types and constants for the CSW1 (compressed square wave) tape recorder.
package csw_recorder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_REC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } csw_state_t;

  localparam int HDR_LEN = 32;

  // Bytes 25, 26 and 28 are placeholders; they are filled from RATE and pol0.
  localparam logic [7:0] CSW_HDR [HDR_LEN] = '{
    8'h43, 8'h6F, 8'h6D, 8'h70, 8'h72, 8'h65, 8'h73, 8'h73, 8'h65, 8'h64,
    8'h20, 8'h53, 8'h71, 8'h75, 8'h61, 8'h72, 8'h65, 8'h20, 8'h57, 8'h61,
    8'h76, 8'h65, 8'h1A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
    8'h00, 8'h00
  };

  localparam logic [7:0]  RLE_LONG_MARK = 8'h00;
  localparam logic [31:0] RLE_SHORT_MAX = 32'd255;

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic [15:0] rate,
                                          input logic pol);
    logic [7:0] b;
    case (idx)
      5'd25:   b = rate[7:0];
      5'd26:   b = rate[15:8];
      5'd28:   b = {7'b0000000, pol};
      default: b = CSW_HDR[idx];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/csw_run_fifo.sv
// Small synchronous FIFO holding pending run lengths between sampler and encoder.
module csw_run_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Status flags and qualified push/pop; a pop frees the slot a same-cycle push needs.
  always_comb begin
    empty     = (r_count == '0);
    full      = (r_count == CNT_FULL);
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    dout      = r_mem[r_rd_ptr];
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/csw_recorder.sv
// Records the Spectrum MIC level as an RLE CSW1 file into a byte buffer with a
// wr/wr_ack handshake.
module csw_recorder
  import csw_recorder_pkg::*;
#(
  parameter int          PRESCALE = 80,
  parameter logic [15:0] RATE     = 16'hAAE6
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        rec,
  input  logic        mic_in,
  input  logic [24:0] max_size,
  output logic        wr,
  output logic [24:0] addr,
  output logic [7:0]  dout,
  input  logic        wr_ack,
  output logic        active,
  output logic        done,
  output logic        overflow,
  output logic [24:0] size
);
  localparam int            PW         = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  csw_state_t    r_state;
  logic          r_rec_d, r_mic_d, r_pol0;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_run_cnt, r_enc_run;
  logic [5:0]    r_hdr_idx;
  logic [2:0]    r_enc_left;
  logic          r_enc_long;
  logic          r_wr, r_active, r_done, r_overflow;
  logic [24:0]   r_addr, r_size;
  logic [7:0]    r_dout;

  logic          w_rec_rise, w_rec_fall, w_start, w_sampling, w_tick, w_edge;
  logic          w_hdr_done, w_push_req, w_push, w_pop, w_accept, w_src_valid;
  logic          w_fifo_full, w_fifo_empty;
  logic [7:0]    w_src_byte, w_enc_byte;
  logic [31:0]   w_fifo_dout;

  csw_run_fifo #(.DEPTH(4), .WIDTH(32)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (w_start),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_run_cnt),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // Edge detection, sample tick, FIFO control and next output byte selection.
  always_comb begin
    w_rec_rise = rec & ~r_rec_d;
    w_rec_fall = ~rec & r_rec_d;
    w_start    = w_rec_rise && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_sampling = (r_state == ST_HDR) || (r_state == ST_REC);
    w_tick     = w_sampling && ce && (r_presc == PRESC_LAST);
    w_edge     = w_tick && (mic_in != r_mic_d);
    w_hdr_done = (r_hdr_idx == 6'd32);
    w_pop      = ((r_state == ST_REC) || (r_state == ST_FLUSH)) && w_hdr_done &&
                 (r_enc_left == 3'd0) && !w_fifo_empty;
    w_accept   = r_wr && wr_ack;
    // Stopping flushes the partial run even without a level change.
    if (w_rec_fall) w_push_req = w_sampling && (r_run_cnt != 32'd0);
    else            w_push_req = w_edge;
    w_push = w_push_req && (!w_fifo_full || w_pop);

    w_enc_byte = r_enc_run[7:0];
    if (r_enc_long) begin
      case (r_enc_left)
        3'd5:    w_enc_byte = RLE_LONG_MARK;
        3'd4:    w_enc_byte = r_enc_run[7:0];
        3'd3:    w_enc_byte = r_enc_run[15:8];
        3'd2:    w_enc_byte = r_enc_run[23:16];
        3'd1:    w_enc_byte = r_enc_run[31:24];
        default: w_enc_byte = 8'h00;
      endcase
    end else begin
      w_enc_byte = r_enc_run[7:0];
    end

    if (!w_hdr_done) begin
      w_src_valid = 1'b1;
      w_src_byte  = hdr_byte(r_hdr_idx[4:0], RATE, r_pol0);
    end else if (r_enc_left != 3'd0) begin
      w_src_valid = 1'b1;
      w_src_byte  = w_enc_byte;
    end else begin
      w_src_valid = 1'b0;
      w_src_byte  = 8'h00;
    end
  end

  // Recorder FSM, sampler, encoder and write port with registered outputs.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rec_d    <= rec;
      r_mic_d    <= mic_in;
      r_pol0     <= 1'b0;
      r_presc    <= '0;
      r_run_cnt  <= 32'd0;
      r_hdr_idx  <= 6'd0;
      r_enc_run  <= 32'd0;
      r_enc_left <= 3'd0;
      r_enc_long <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= 25'd0;
      r_size     <= 25'd0;
      r_dout     <= 8'h00;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rec_d <= rec;
      if (w_start) begin
        r_state    <= ST_HDR;
        r_pol0     <= mic_in;
        r_mic_d    <= mic_in;
        r_presc    <= '0;
        r_run_cnt  <= 32'd1;
        r_hdr_idx  <= 6'd0;
        r_enc_left <= 3'd0;
        r_enc_long <= 1'b0;
        r_wr       <= 1'b0;
        r_addr     <= 25'd0;
        r_size     <= 25'd0;
        r_active   <= 1'b1;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_sampling && ce) r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          r_mic_d <= mic_in;
          if (w_edge)                         r_run_cnt <= 32'd1;
          else if (r_run_cnt != 32'hFFFFFFFF) r_run_cnt <= r_run_cnt + 32'd1;
        end
        if (w_push_req && !w_push) r_overflow <= 1'b1;
        if (w_pop) begin
          r_enc_run  <= w_fifo_dout;
          r_enc_long <= (w_fifo_dout > RLE_SHORT_MAX);
          r_enc_left <= (w_fifo_dout > RLE_SHORT_MAX) ? 3'd5 : 3'd1;
        end

        case (r_state)
          ST_HDR: begin
            if (w_rec_fall)                             r_state <= ST_FLUSH;
            else if (w_accept && (r_hdr_idx == 6'd31)) r_state <= ST_REC;
          end
          ST_REC: begin
            if (w_rec_fall) r_state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            if (w_hdr_done && w_fifo_empty && (r_enc_left == 3'd0) && !r_wr) begin
              r_state  <= ST_DONE;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
          end
          default: ;
        endcase

        // A full buffer ends the recording; this overrides any transition above.
        if (w_accept) begin
          r_wr   <= 1'b0;
          r_addr <= r_addr + 25'd1;
          r_size <= r_size + 25'd1;
          if (!w_hdr_done) r_hdr_idx  <= r_hdr_idx + 6'd1;
          else             r_enc_left <= r_enc_left - 3'd1;
        end else if (!r_wr && r_active && w_src_valid) begin
          if (r_addr == max_size) begin
            r_overflow <= 1'b1;
            r_state    <= ST_DONE;
            r_active   <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_wr   <= 1'b1;
            r_dout <= w_src_byte;
          end
        end
      end
    end
  end

  assign wr       = r_wr;
  assign addr     = r_addr;
  assign dout     = r_dout;
  assign size     = r_size;
  assign active   = r_active;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
